// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads words over a req/ack memory bus and
// hands them to the decoder with a DOR / ack_from_next handshake; supports redirects.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_data,
   output logic        DOR,
   input  logic        ack_from_next,
   output logic [31:0] data_out,
   input  logic        pc_load,
   input  logic [31:0] pc_load_value,
   output logic [31:0] pc_out,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {IDLE, REQ, PRESENT, RELEASE} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] data_q, data_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] pend_val_q, pend_val_d;
   logic        mem_req_q, mem_req_d;
   logic        dor_q, dor_d;
   logic        pend_q, pend_d;
   logic        discard_q, discard_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         data_q     <= '0;
         cnt_q      <= '0;
         pend_val_q <= '0;
         mem_req_q  <= 1'b0;
         dor_q      <= 1'b0;
         pend_q     <= 1'b0;
         discard_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         pend_val_q <= pend_val_d;
         mem_req_q  <= mem_req_d;
         dor_q      <= dor_d;
         pend_q     <= pend_d;
         discard_q  <= discard_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      pend_val_d = pend_val_q;
      mem_req_d  = mem_req_q;
      dor_d      = dor_q;
      pend_d     = pend_q;
      discard_d  = discard_q;
      unique case (state_q)
         IDLE: begin
            if (pc_load) pc_d = pc_load_value;
            mem_req_d = 1'b1;
            state_d   = REQ;
         end
         REQ: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               pend_d    = 1'b0;
               discard_d = 1'b0;
               // A redirect racing the ack, or one seen earlier, drops the returned word.
               if (pc_load) begin
                  pc_d    = pc_load_value;
                  state_d = IDLE;
               end else if (discard_q) begin
                  pc_d    = pend_val_q;
                  state_d = IDLE;
               end else begin
                  data_d  = mem_data;
                  dor_d   = 1'b1;
                  state_d = PRESENT;
               end
            end else if (pc_load) begin
               pend_val_d = pc_load_value;
               pend_d     = 1'b1;
               discard_d  = 1'b1;
            end
         end
         PRESENT: begin
            if (pc_load) begin
               pend_val_d = pc_load_value;
               pend_d     = 1'b1;
            end
            if (ack_from_next) begin
               dor_d   = 1'b0;
               cnt_d   = cnt_q + 32'd1;
               pend_d  = 1'b0;
               state_d = RELEASE;
               if (pc_load)     pc_d = pc_load_value;
               else if (pend_q) pc_d = pend_val_q;
               else             pc_d = pc_q + PC_STEP;
            end
         end
         RELEASE: begin
            if (pc_load) begin
               pc_d   = pc_load_value;
               pend_d = 1'b0;
            end
            // Decoder holds ack as a level; wait for it to drop before fetching again.
            if (!ack_from_next) begin
               mem_req_d = 1'b1;
               state_d   = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = pc_q;
   assign DOR         = dor_q;
   assign data_out    = data_q;
   assign pc_out      = pc_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stimulus pushes expected {pc,word} pairs, a monitor
// pops them whenever the decoder accepts a presented word.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_data = '0;
   logic        DOR;
   logic        ack_from_next = 1'b0;
   logic [31:0] data_out;
   logic        pc_load = 1'b0;
   logic [31:0] pc_load_value = '0;
   logic [31:0] pc_out;
   logic [31:0] fetch_count;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [63:0] exp_q[$];

   instr_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
      .clk(clk), .reset(reset),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
      .DOR(DOR), .ack_from_next(ack_from_next), .data_out(data_out),
      .pc_load(pc_load), .pc_load_value(pc_load_value),
      .pc_out(pc_out), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!mem_req && n < 20) begin
         step();
         n++;
      end
      chk("mem_req_wait", {31'd0, mem_req}, 32'd1);
   endtask

   task automatic serve(input logic [31:0] a, input logic [31:0] d, input int dly, input bit deliver);
      wait_req();
      chk("req_addr", mem_addr, a);
      repeat (dly) begin
         step();
         chk("req_hold", {31'd0, mem_req}, 32'd1);
         chk("addr_hold", mem_addr, a);
      end
      mem_ack  = 1'b1;
      mem_data = d;
      if (deliver) exp_q.push_back({a, d});
      step();
      mem_ack  = 1'b0;
      mem_data = '0;
      chk("dor_after_ack", {31'd0, DOR}, {31'd0, deliver});
      chk("req_drop", {31'd0, mem_req}, 32'd0);
      if (deliver) chk("data_out", data_out, d);
   endtask

   task automatic accept(input int hold);
      ack_from_next = 1'b1;
      step();
      chk("dor_fall", {31'd0, DOR}, 32'd0);
      for (int i = 1; i < hold; i++) begin
         chk("no_req_while_ack", {31'd0, mem_req}, 32'd0);
         step();
      end
      chk("no_req_while_ack", {31'd0, mem_req}, 32'd0);
      ack_from_next = 1'b0;
      step();
      chk("req_after_ack_fall", {31'd0, mem_req}, 32'd1);
   endtask

   // Scoreboard monitor: the edge after a negedge with DOR && ack is an acceptance.
   always @(negedge clk) begin
      if (!reset && DOR && ack_from_next) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_delivery: got %h at pc %h expected nothing", data_out, pc_out);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("deliver_word", data_out, e[31:0]);
            chk("deliver_pc", pc_out, e[63:32]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish by 100000");
      $fatal(1);
   end

   initial begin
      #2;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_dor", {31'd0, DOR}, 32'd0);
      chk("rst_data_out", data_out, 32'd0);
      chk("rst_pc_out", pc_out, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_fetch_count", fetch_count, 32'd0);
      step();
      reset = 1'b0;
      step();
      chk("req_one_edge", {31'd0, mem_req}, 32'd1);
      chk("first_addr", mem_addr, 32'd0);

      serve(32'h0, 32'h0085_1020, 2, 1'b1);
      accept(4);
      chk("cnt_after_first", fetch_count, 32'd1);
      chk("addr_after_first", mem_addr, 32'd4);

      serve(32'h4, 32'h8c22_0004, 0, 1'b1);
      accept(1);
      serve(32'h8, 32'hac23_0008, 1, 1'b1);
      accept(1);
      chk("cnt_three", fetch_count, 32'd3);
      chk("pc_twelve", pc_out, 32'd12);

      // Redirect while a read is outstanding: returned word must be dropped.
      wait_req();
      pc_load = 1'b1; pc_load_value = 32'h100;
      step();
      pc_load = 1'b0;
      chk("addr_stable_on_load", mem_addr, 32'd12);
      chk("req_stable_on_load", {31'd0, mem_req}, 32'd1);
      step();
      mem_ack = 1'b1; mem_data = 32'hdead_beef;
      step();
      mem_ack = 1'b0; mem_data = '0;
      chk("discard_no_dor", {31'd0, DOR}, 32'd0);
      chk("discard_req_drop", {31'd0, mem_req}, 32'd0);
      step();
      chk("redirect_req", {31'd0, mem_req}, 32'd1);
      chk("redirect_addr", mem_addr, 32'h100);

      // Redirects while presenting: word still delivered, last target wins.
      serve(32'h100, 32'h00a5_2820, 0, 1'b1);
      pc_load = 1'b1; pc_load_value = 32'h200;
      step();
      pc_load = 1'b0;
      chk("present_dor_held", {31'd0, DOR}, 32'd1);
      chk("present_data_held", data_out, 32'h00a5_2820);
      step();
      pc_load = 1'b1; pc_load_value = 32'h300;
      step();
      pc_load = 1'b0;
      accept(2);
      chk("cnt_four", fetch_count, 32'd4);
      chk("last_load_wins", mem_addr, 32'h300);

      // pc_load on the same edge as mem_ack.
      mem_ack = 1'b1; mem_data = 32'h1234_5678;
      pc_load = 1'b1; pc_load_value = 32'h400;
      step();
      mem_ack = 1'b0; pc_load = 1'b0;
      chk("same_edge_no_dor", {31'd0, DOR}, 32'd0);
      step();
      chk("same_edge_req", {31'd0, mem_req}, 32'd1);
      chk("same_edge_addr", mem_addr, 32'h400);

      // Async reset mid-REQ, then a stray ack while IDLE.
      reset = 1'b1;
      #2;
      chk("async_rst_req", {31'd0, mem_req}, 32'd0);
      chk("async_rst_dor", {31'd0, DOR}, 32'd0);
      chk("async_rst_pc", pc_out, 32'd0);
      chk("async_rst_cnt", fetch_count, 32'd0);
      step();
      reset = 1'b0;
      mem_ack = 1'b1; mem_data = 32'h1111_1111;
      step();
      mem_ack = 1'b0; mem_data = '0;
      chk("idle_ack_ignored_dor", {31'd0, DOR}, 32'd0);
      chk("idle_ack_ignored_data", data_out, 32'd0);
      chk("restart_req", {31'd0, mem_req}, 32'd1);
      chk("restart_addr", mem_addr, 32'd0);

      // PC wrap from 0xFFFF_FFFC.
      pc_load = 1'b1; pc_load_value = 32'hFFFF_FFFC;
      step();
      pc_load = 1'b0;
      mem_ack = 1'b1; mem_data = 32'h2222_2222;
      step();
      mem_ack = 1'b0; mem_data = '0;
      chk("wrap_discard_dor", {31'd0, DOR}, 32'd0);
      serve(32'hFFFF_FFFC, 32'h0000_0013, 0, 1'b1);
      accept(1);
      chk("wrap_addr", mem_addr, 32'd0);
      chk("wrap_cnt", fetch_count, 32'd1);

      // Redirect during RELEASE applies immediately.
      serve(32'h0, 32'h0010_8093, 0, 1'b1);
      ack_from_next = 1'b1;
      step();
      chk("rel_dor_fall", {31'd0, DOR}, 32'd0);
      pc_load = 1'b1; pc_load_value = 32'h500;
      step();
      pc_load = 1'b0;
      chk("rel_no_req", {31'd0, mem_req}, 32'd0);
      chk("rel_pc_now", pc_out, 32'h500);
      ack_from_next = 1'b0;
      step();
      chk("rel_req", {31'd0, mem_req}, 32'd1);
      chk("rel_addr", mem_addr, 32'h500);
      chk("rel_cnt", fetch_count, 32'd2);

      step();
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
